// File: rtl/barrett_modmul_pipe_if.sv
// Operand/result stream bundle for barrett_modmul_pipe: input channel (A, B, op, tag) and result
// channel (C, tag), both valid/ready. The slave modport is the multiplier side.
interface barrett_modmul_pipe_if #(
  parameter int unsigned W     = 32,
  parameter int unsigned TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_c;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_c, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_c, out_tag
  );
endinterface

// File: rtl/barrett_modmul_pipe.sv
// Five-stage pipelined Barrett modular multiplier, C = (A*B) mod P, valid/ready on both sides.
// Define BARRETT_ADDSUB_EN to add modular add (op 01) and sub (op 10) sharing the correction stage.
module barrett_modmul_pipe #(
  parameter int unsigned W     = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [W-1:0]         cfg_p,
  // T = floor(2^(2W)/P) needs up to 2W bits once P sits well below 2^(W-1)
  input  logic [2*W-1:0]       cfg_t,
  output logic                 busy,
  barrett_modmul_pipe_if.slave bus
);
  localparam int unsigned LAT = 5;
  localparam int unsigned XW  = 2 * W;
  localparam int unsigned RW  = 4 * W;

  logic [W-1:0]     p_q, p_d;
  logic [XW-1:0]    t_q, t_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic             stall, accept, cfg_ld, in_ready;
  logic             en1, en2, en3, en4, en5;

  logic [XW-1:0]    s1_x_q, s1_x_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_byp_q, s1_byp_d;
  logic [W:0]       s2_quo_q, s2_quo_d, s2_xlo_q, s2_xlo_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_byp_q, s2_byp_d;
  logic [W:0]       s3_y_q, s3_y_d, s3_xlo_q, s3_xlo_d;
  logic [TAG_W-1:0] s3_tag_q, s3_tag_d;
  logic [W:0]       s4_r_q, s4_r_d;
  logic [TAG_W-1:0] s4_tag_q, s4_tag_d;
  logic [W-1:0]     s5_c_q, s5_c_d;
  logic [TAG_W-1:0] s5_tag_q, s5_tag_d;

  logic [RW-1:0]    r_full;
  logic [W:0]       corr;
  logic             unused_bits;

  // A stage advances when it is empty or its successor advances, so bubbles squeeze out under stall.
  always_comb begin
    stall    = vld_q[LAT-1] & ~bus.out_ready;
    en5      = ~stall;
    en4      = ~vld_q[3] | en5;
    en3      = ~vld_q[2] | en4;
    en2      = ~vld_q[1] | en3;
    en1      = ~vld_q[0] | en2;
    in_ready = ~stall & ~cfg_we;
    accept   = bus.in_valid & in_ready;
    busy     = |vld_q;
    cfg_ld   = cfg_we & ~busy & ~accept;
    p_d      = cfg_ld ? cfg_p : p_q;
    t_d      = cfg_ld ? cfg_t : t_q;
    vld_d[0] = en1 ? accept   : vld_q[0];
    vld_d[1] = en2 ? vld_q[0] : vld_q[1];
    vld_d[2] = en3 ? vld_q[1] : vld_q[2];
    vld_d[3] = en4 ? vld_q[2] : vld_q[3];
    vld_d[4] = en5 ? vld_q[3] : vld_q[4];
  end

  // S1: full product, or the pre-reduced add/sub value with the reduction stages bypassed.
  always_comb begin
    s1_x_d   = s1_x_q;
    s1_tag_d = s1_tag_q;
    s1_byp_d = s1_byp_q;
    if (en1) begin
      s1_x_d   = XW'(bus.in_a) * XW'(bus.in_b);
      s1_tag_d = bus.in_tag;
      s1_byp_d = 1'b0;
`ifdef BARRETT_ADDSUB_EN
      if (bus.in_op == 2'b01) begin
        s1_x_d   = XW'({1'b0, bus.in_a} + {1'b0, bus.in_b});
        s1_byp_d = 1'b1;
      end else if (bus.in_op == 2'b10) begin
        s1_x_d   = XW'({1'b0, bus.in_a} + {1'b0, p_q} - {1'b0, bus.in_b});
        s1_byp_d = 1'b1;
      end
`endif
    end
  end

  // S2: quotient estimate floor(X*T / 2^(2W)), at most 1 below floor(X/P).
  always_comb begin
    r_full   = RW'(s1_x_q) * RW'(t_q);
    s2_quo_d = s2_quo_q;
    s2_xlo_d = s2_xlo_q;
    s2_tag_d = s2_tag_q;
    s2_byp_d = s2_byp_q;
    if (en2) begin
      s2_quo_d = r_full[3*W:2*W];
      s2_xlo_d = s1_x_q[W:0];
      s2_tag_d = s1_tag_q;
      s2_byp_d = s1_byp_q;
    end
  end

  always_comb begin
    s3_y_d   = s3_y_q;
    s3_xlo_d = s3_xlo_q;
    s3_tag_d = s3_tag_q;
    if (en3) begin
      s3_y_d   = s2_byp_q ? '0 : s2_quo_q * {1'b0, p_q};
      s3_xlo_d = s2_xlo_q;
      s3_tag_d = s2_tag_q;
    end
  end

  // S4 wraps mod 2^(W+1); the true remainder is below 3P so no information is lost.
  always_comb begin
    s4_r_d   = s4_r_q;
    s4_tag_d = s4_tag_q;
    if (en4) begin
      s4_r_d   = s3_xlo_q - s3_y_q;
      s4_tag_d = s3_tag_q;
    end
  end

  always_comb begin
    if (s4_r_q >= {p_q, 1'b0}) begin
      corr = s4_r_q - {p_q, 1'b0};
    end else if (s4_r_q >= {1'b0, p_q}) begin
      corr = s4_r_q - {1'b0, p_q};
    end else begin
      corr = s4_r_q;
    end
    s5_c_d   = en5 ? corr[W-1:0] : s5_c_q;
    s5_tag_d = en5 ? s4_tag_q    : s5_tag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q      <= '0;
      t_q      <= '0;
      vld_q    <= '0;
      s1_x_q   <= '0;
      s1_tag_q <= '0;
      s1_byp_q <= 1'b0;
      s2_quo_q <= '0;
      s2_xlo_q <= '0;
      s2_tag_q <= '0;
      s2_byp_q <= 1'b0;
      s3_y_q   <= '0;
      s3_xlo_q <= '0;
      s3_tag_q <= '0;
      s4_r_q   <= '0;
      s4_tag_q <= '0;
      s5_c_q   <= '0;
      s5_tag_q <= '0;
    end else begin
      p_q      <= p_d;
      t_q      <= t_d;
      vld_q    <= vld_d;
      s1_x_q   <= s1_x_d;
      s1_tag_q <= s1_tag_d;
      s1_byp_q <= s1_byp_d;
      s2_quo_q <= s2_quo_d;
      s2_xlo_q <= s2_xlo_d;
      s2_tag_q <= s2_tag_d;
      s2_byp_q <= s2_byp_d;
      s3_y_q   <= s3_y_d;
      s3_xlo_q <= s3_xlo_d;
      s3_tag_q <= s3_tag_d;
      s4_r_q   <= s4_r_d;
      s4_tag_q <= s4_tag_d;
      s5_c_q   <= s5_c_d;
      s5_tag_q <= s5_tag_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_q[LAT-1];
  assign bus.out_c     = s5_c_q;
  assign bus.out_tag   = s5_tag_q;

`ifdef BARRETT_ADDSUB_EN
  assign unused_bits = ^{r_full[RW-1:3*W+1], r_full[2*W-1:0], corr[W]};
`else
  assign unused_bits = ^{r_full[RW-1:3*W+1], r_full[2*W-1:0], corr[W], bus.in_op};
`endif
endmodule

// File: tb/tb_barrett_modmul_pipe.sv
// Self-checking bench for barrett_modmul_pipe: directed scenarios plus a randomized stream
// compared in order against a plain-arithmetic model of (A op B) mod P.
module tb_barrett_modmul_pipe;
  localparam int unsigned W     = 32;
  localparam int unsigned TAG_W = 8;

  typedef struct packed {
    logic [W-1:0]     c;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic           clk, rst, cfg_we, busy;
  logic [W-1:0]   cfg_p;
  logic [2*W-1:0] cfg_t;
  logic [W-1:0]   cur_p;
  int             n_checks, n_fail;
  res_t           exp_q[$];
  res_t           obs_q[$];

  barrett_modmul_pipe_if #(.W(W), .TAG_W(TAG_W)) bus ();

  barrett_modmul_pipe #(.W(W), .TAG_W(TAG_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .cfg_we (cfg_we),
    .cfg_p  (cfg_p),
    .cfg_t  (cfg_t),
    .busy   (busy),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op, input logic [W-1:0] p);
    longint unsigned la, lb, lp;
    la = a;
    lb = b;
    lp = p;
`ifdef BARRETT_ADDSUB_EN
    if (op == 2'b01) return W'((la + lb) % lp);
    if (op == 2'b10) return W'((la + lp - lb) % lp);
`else
    if (op == 2'b11) return W'((la * lb) % lp);
`endif
    return W'((la * lb) % lp);
  endfunction

  function automatic logic [2*W-1:0] calc_t(input logic [W-1:0] p);
    logic [2*W:0] num, den, quo;
    num         = '0;
    num[2*W]    = 1'b1;
    den         = '0;
    den[W-1:0]  = p;
    quo         = num / den;
    return quo[2*W-1:0];
  endfunction

  // One cycle: drive at the falling edge, then log what the next rising edge will transfer.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, input logic [TAG_W-1:0] tag, input logic ordy,
                      output logic acc, output logic hand);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_op     = op;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    #1;
    acc  = bus.in_valid & bus.in_ready;
    hand = bus.out_valid & bus.out_ready;
    if (acc) exp_q.push_back('{c: model(a, b, op, cur_p), tag: tag});
    if (hand) obs_q.push_back('{c: bus.out_c, tag: bus.out_tag});
  endtask

  task automatic load_cfg(input logic [W-1:0] p);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cfg_we       = 1'b1;
    cfg_p        = p;
    cfg_t        = calc_t(p);
    @(negedge clk);
    cfg_we       = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc, hand;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 2'b00, '0, 1'b1, acc, hand);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_c !== '0) begin
      n_fail++; $display("FAIL reset_out_c: got %0d want 0", bus.out_c);
    end
    n_checks++;
    if (bus.out_tag !== '0) begin
      n_fail++; $display("FAIL reset_out_tag: got %0d want 0", bus.out_tag);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic acc, hand;
    int   lat;
    load_cfg(32'd12289);
    cur_p = 32'd12289;
    step(1'b1, 32'd12288, 32'd12288, 2'b00, 8'h5a, 1'b1, acc, hand);
    n_checks++;
    if (acc !== 1'b1) begin
      n_fail++; $display("FAIL lat_accept: got %b want 1", acc);
    end
    lat = 0;
    for (int j = 1; j <= 20; j++) begin
      step(1'b0, '0, '0, 2'b00, '0, 1'b1, acc, hand);
      if (hand && lat == 0) begin
        lat = j;
        n_checks++;
        if (bus.out_c !== 32'd1 || bus.out_tag !== 8'h5a) begin
          n_fail++;
          $display("FAIL lat_result: got c=%0d tag=%0h want c=1 tag=5a", bus.out_c, bus.out_tag);
        end
      end
    end
    n_checks++;
    if (lat != 5) begin
      n_fail++; $display("FAIL lat_cycles: got %0d want 5", lat);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic acc, hand;
    int   seen;
    step(1'b1, 32'd5, 32'd7, 2'b00, 8'd1, 1'b1, acc, hand);
    step(1'b1, 32'd0, 32'd12288, 2'b00, 8'd2, 1'b1, acc, hand);
    seen = 0;
    for (int j = 2; j <= 20; j++) begin
      step(1'b0, '0, '0, 2'b00, '0, 1'b1, acc, hand);
      if (hand) begin
        seen++;
        n_checks++;
        if (seen == 1 && (j != 5 || bus.out_c !== 32'd35 || bus.out_tag !== 8'd1)) begin
          n_fail++;
          $display("FAIL b2b_first: got cyc=%0d c=%0d tag=%0d want cyc=5 c=35 tag=1",
                   j, bus.out_c, bus.out_tag);
        end
        if (seen == 2 && (j != 6 || bus.out_c !== 32'd0 || bus.out_tag !== 8'd2)) begin
          n_fail++;
          $display("FAIL b2b_second: got cyc=%0d c=%0d tag=%0d want cyc=6 c=0 tag=2",
                   j, bus.out_c, bus.out_tag);
        end
      end
    end
    n_checks++;
    if (seen != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d results want 2", seen);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_random();
    logic       acc, hand, v, r;
    logic [1:0] op;
    int         issued;
    res_t       o, e;
    issued = 0;
    for (int cyc = 0; cyc < 20000 && (issued < 1000 || exp_q.size() > obs_q.size()); cyc++) begin
      v  = (issued < 1000) && ($urandom_range(0, 9) < 8);
      r  = $urandom_range(0, 9) < 7;
      op = 2'($urandom_range(0, 3));
      step(v, $urandom_range(0, cur_p - 1), $urandom_range(0, cur_p - 1), op,
           TAG_W'(issued), r, acc, hand);
      if (acc) issued++;
    end
    n_checks++;
    if (obs_q.size() != 1000 || exp_q.size() != 1000) begin
      n_fail++;
      $display("FAIL rand_count: got %0d results want %0d (issued %0d)",
               obs_q.size(), exp_q.size(), issued);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rand_result: got c=%0d tag=%0d want c=%0d tag=%0d", o.c, o.tag, e.c, e.tag);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_stall();
    logic acc, hand;
    res_t o, e;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, $urandom_range(1, cur_p - 1), $urandom_range(1, cur_p - 1), 2'b00,
           TAG_W'(8'h80 + i), 1'b1, acc, hand);
    end
    n_checks++;
    if (exp_q.size() != 5) begin
      n_fail++; $display("FAIL stall_fill: got %0d accepts want 5", exp_q.size());
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'd1, 32'd1, 2'b00, 8'hee, 1'b0, acc, hand);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_in_ready: cycle %0d got %b want 0", i, bus.in_ready);
      end
      n_checks++;
      if (exp_q.size() == 0 || bus.out_valid !== 1'b1 ||
          bus.out_c !== exp_q[0].c || bus.out_tag !== exp_q[0].tag) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d got v=%b c=%0d tag=%0d want held first result",
                 i, bus.out_valid, bus.out_c, bus.out_tag);
      end
    end
    idle(20);
    n_checks++;
    if (obs_q.size() != 5 || exp_q.size() != 5) begin
      n_fail++; $display("FAIL stall_count: got %0d results want 5", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stall_result: got c=%0d tag=%0d want c=%0d tag=%0d", o.c, o.tag, e.c, e.tag);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_cfg_busy();
    logic acc, hand;
    res_t o, e;
    step(1'b1, 32'd100, 32'd200, 2'b00, 8'h11, 1'b1, acc, hand);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cfg_we       = 1'b1;
    cfg_p        = 32'd7681;
    cfg_t        = calc_t(32'd7681);
    #1;
    n_checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL cfg_busy_state: got busy=%b in_ready=%b want 1 0", busy, bus.in_ready);
    end
    @(negedge clk);
    cfg_we = 1'b0;
    idle(10);
    step(1'b1, 32'd100, 32'd200, 2'b00, 8'h12, 1'b1, acc, hand);
    idle(10);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL cfg_drain_busy: got %b want 0", busy);
    end
    load_cfg(32'd7681);
    cur_p = 32'd7681;
    step(1'b1, 32'd7680, 32'd2, 2'b00, 8'h13, 1'b1, acc, hand);
    idle(10);
    n_checks++;
    if (obs_q.size() != 3 || obs_q[0].c !== 32'd7711 || obs_q[2].c !== 32'd7679) begin
      n_fail++;
      $display("FAIL cfg_values: got %0d results want 3 with c=7711,7711,7679", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL cfg_result: got c=%0d tag=%0d want c=%0d tag=%0d", o.c, o.tag, e.c, e.tag);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

`ifdef BARRETT_ADDSUB_EN
  task automatic test_addsub();
    logic acc, hand;
    res_t o, e;
    load_cfg(32'd12289);
    cur_p = 32'd12289;
    step(1'b1, 32'd12288, 32'd1, 2'b01, 8'd21, 1'b1, acc, hand);
    step(1'b1, 32'd0, 32'd1, 2'b10, 8'd22, 1'b1, acc, hand);
    step(1'b1, 32'd5, 32'd7, 2'b00, 8'd23, 1'b1, acc, hand);
    step(1'b1, 32'd3, 32'd4, 2'b01, 8'd24, 1'b1, acc, hand);
    step(1'b1, 32'd10, 32'd3, 2'b10, 8'd25, 1'b1, acc, hand);
    step(1'b1, 32'd9, 32'd9, 2'b11, 8'd26, 1'b1, acc, hand);
    idle(12);
    n_checks++;
    if (obs_q.size() != 6 || obs_q[0].c !== 32'd0 || obs_q[1].c !== 32'd12288) begin
      n_fail++;
      $display("FAIL addsub_values: got %0d results want 6 starting c=0,12288", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL addsub_result: got c=%0d tag=%0d want c=%0d tag=%0d", o.c, o.tag, e.c, e.tag);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask
`endif

  task automatic test_reset_midflight();
    logic acc, hand;
    load_cfg(32'd12289);
    cur_p = 32'd12289;
    for (int i = 0; i < 3; i++) step(1'b1, 32'd5, 32'd7, 2'b00, TAG_W'(40 + i), 1'b1, acc, hand);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 2'b00, '0, 1'b0, acc, hand);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_c !== 32'd35 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got v=%b c=%0d busy=%b want 1 35 1", bus.out_valid, bus.out_c, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_c !== '0 || bus.out_tag !== '0 || busy !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_outputs: got v=%b c=%0d tag=%0d busy=%b rdy=%b want 0 0 0 0 1",
               bus.out_valid, bus.out_c, bus.out_tag, busy, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    load_cfg(32'd12289);
    step(1'b1, 32'd12288, 32'd12288, 2'b00, 8'h77, 1'b1, acc, hand);
    idle(10);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0].c !== 32'd1 || obs_q[0].tag !== 8'h77) begin
      n_fail++; $display("FAIL midrst_recover: got %0d results want one c=1 tag=77", obs_q.size());
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    cur_p         = '0;
    rst           = 1'b0;
    cfg_we        = 1'b0;
    cfg_p         = '0;
    cfg_t         = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 2'b00;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_latency();
    test_back_to_back();
    test_random();
    test_stall();
    test_cfg_busy();
`ifdef BARRETT_ADDSUB_EN
    test_addsub();
`endif
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
